// File: rtl/led_pulse_stretcher_if.sv
// Event/LED bundle for led_pulse_stretcher. The master drives trigger.
// The slave is the stretcher, which returns the LED drive and the queue status.
interface led_pulse_stretcher_if #(
  parameter int PEND_W = 4
);
  logic              trigger;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output trigger,
    input  led,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  trigger,
    output led,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle trigger events into fixed-length LED blinks, each followed by an off-gap.
// Events that arrive during a blink are queued in a saturating counter.
module led_pulse_stretcher #(
  parameter int ON_CYCLES  = 65535,
  parameter int OFF_CYCLES = 65535,
  parameter int PEND_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_pulse_stretcher_if.slave  bus
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  // The timer counts down from N-1 to 0, so it only has to hold MAX_CYC-1.
  localparam int TMR_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic [PEND_W-1:0] pending_reg, pending_next;
  logic              led_reg;
  logic              overflow_reg, overflow_next;

  logic timer_done;
  logic demand;
  logic start;
  logic pend_inc;
  logic pend_dec;

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    pending_next  = pending_reg;
    overflow_next = 1'b0;
    start         = 1'b0;
    timer_done    = (timer_reg == '0);
    demand        = bus.trigger || (pending_reg != '0);

    case (state_reg)
      IDLE: begin
        if (demand) begin
          start = 1'b1;
        end
      end
      ON: begin
        if (timer_done) begin
          state_next = GAP;
          timer_next = OFF_LOAD;
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end
      GAP: begin
        if (timer_done) begin
          if (demand) begin
            start = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase

    if (start) begin
      state_next = ON;
      timer_next = ON_LOAD;
    end

    // A blink start drains the queue first; a trigger it doesn't consume gets queued.
    pend_dec = start && (pending_reg != '0);
    pend_inc = bus.trigger && !(start && (pending_reg == '0));

    if (pend_inc && !pend_dec) begin
      if (pending_reg == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending_reg + PEND_W'(1);
      end
    end else if (pend_dec && !pend_inc) begin
      pending_next = pending_reg - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      pending_reg  <= '0;
      led_reg      <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      pending_reg  <= pending_next;
      led_reg      <= (state_next == ON);
      overflow_reg <= overflow_next;
    end
  end

  assign bus.led      = led_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.pending  = pending_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: doc/led_pulse_stretcher.md
LED_PULSE_STRETCHER -- requirements
Module: led_pulse_stretcher

Interface
REQ-001 Parameter ON_CYCLES, default 65535: LED on-time per blink, in clk cycles; SHALL be >= 1.
REQ-002 Parameter OFF_CYCLES, default 65535: minimum LED off-gap after each blink, in clk cycles; SHALL be >= 1.
REQ-003 Parameter PEND_W, default 4: width of the pending-event counter; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 trigger  input  1  synchronous event; each high cycle SHALL request one blink.
REQ-007 led  output  1  registered; active-high LED drive.
REQ-008 busy  output  1  high while state != IDLE.
REQ-009 pending  output  PEND_W  number of queued, not-yet-started blinks.
REQ-010 overflow  output  1  registered; one-cycle pulse when a trigger is dropped.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ON and GAP.
REQ-012 led SHALL be 1 exactly while the state is ON; busy SHALL be a combinational decode of the state.
REQ-013 IDLE with trigger=1 or pending>0 SHALL enter ON at the next edge and load the timer for ON_CYCLES cycles.
- Otherwise IDLE SHALL remain IDLE.
REQ-014 ON SHALL last exactly ON_CYCLES cycles, then enter GAP for exactly OFF_CYCLES cycles.
REQ-015 On the last GAP cycle, trigger=1 or pending>0 SHALL enter ON directly, with no IDLE cycle; otherwise the state SHALL go to IDLE.
REQ-016 Start-of-blink consumption order:
- If pending>0, start a blink by decrementing pending.
- If pending=0 and trigger=1, start a blink by consuming the trigger directly; pending stays 0.
REQ-017 A trigger not consumed by a blink start SHALL increment pending.
REQ-018 A simultaneous increment and decrement SHALL leave pending unchanged and SHALL NOT raise overflow, even when pending is saturated.
REQ-019 pending SHALL saturate at 2^PEND_W-1 and SHALL never wrap.
REQ-020 A trigger that would increment a saturated pending SHALL be dropped, and overflow SHALL be 1 on the following cycle only.
REQ-021 Latency from a trigger in IDLE with pending=0 to led=1 SHALL be exactly one cycle.
REQ-022 The timer width SHALL be sized for max(ON_CYCLES, OFF_CYCLES); there SHALL be no off-by-one at terminal count.
REQ-023 Every accepted trigger SHALL produce exactly one distinct blink; blinks SHALL never merge.

Reset
REQ-024 While rst_n=0, the block SHALL force asynchronously: state=IDLE, led=0, overflow=0, pending=0, timer=0.
REQ-025 Triggers SHALL be ignored while rst_n=0.
REQ-026 Reset mid-blink SHALL discard the blink and all queued blinks; no blink SHALL occur after release without a new trigger.
REQ-027 The first edge after rst_n rises SHALL evaluate normally from IDLE.

Verification (ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2; cycle n = edge n)
REQ-028 Single trigger at cycle 0 -> led=1 cycles 1-4, led=0 cycles 5-7, busy=0 from cycle 8, pending=0 throughout.
REQ-029 Triggers at cycles 0, 1, 2 -> pending peaks at 2; three 4-cycle blinks start at cycles 1, 8 and 15; IDLE at cycle 22.
REQ-030 Triggers on cycles 0-4 -> pending reaches 3 at cycle 4; overflow=1 at cycle 5 only; exactly 4 blinks total.
REQ-031 Trigger on the last GAP cycle (cycle 7 after a cycle-0 trigger) -> led=1 at cycle 8, no IDLE cycle, pending stays 0.
REQ-032 Saturated pending=3 and a trigger on a blink-start edge -> pending stays 3, overflow stays 0.
REQ-033 rst_n low during ON with pending=2 -> led=0 immediately without waiting for clk, pending=0; after release, no led activity for 20 cycles without trigger.
